// File: rtl/button_press_counter_pkg.sv
// Shared definitions for the push-button debouncer/press counter:
// FSM state encoding and the sample-tick divider constants.
package button_press_counter_pkg;

  typedef enum logic [1:0] {
    ST_RELEASED     = 2'd0,
    ST_PRESS_PEND   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_PEND = 2'd3
  } btn_state_e;

  localparam int unsigned TICK_DIV_SYN = 32'd802;
  localparam int unsigned TICK_DIV_SIM = 32'd12;

endpackage

// File: rtl/button_press_counter_tick_prescaler.sv
// Free-running divider producing a one-cycle tick every TICK_DIV clocks.
// Reusable wherever a slow enable strobe is needed.
module tick_prescaler
  import button_press_counter_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_SYN
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Wrap to zero after the last count.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Prescaler state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/button_press_counter.sv
// Synchronises and debounces a bouncy push-button, emits press/release/long-press
// pulses and keeps a wrapping count of accepted presses.
module button_press_counter
  import button_press_counter_pkg::*;
#(
  parameter int unsigned TICK_DIV     = TICK_DIV_SYN,
  parameter int unsigned STABLE_TICKS = 4,
  parameter int unsigned LONG_TICKS   = 500,
  parameter int unsigned CNT_W        = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_in,
  input  logic             clr,
  output logic             btn_level,
  output logic             press_pulse,
  output logic             release_pulse,
  output logic             long_pulse,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned SW = $clog2(STABLE_TICKS) + 1;
  localparam int unsigned HW = $clog2(LONG_TICKS + 1);
  localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_TICKS - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_TICKS);
  localparam logic [HW-1:0] HOLD_PRE  = HW'(LONG_TICKS - 1);

  logic             tick_s;
  logic [1:0]       sync_q;
  logic             btn_s;

  btn_state_e       state_q, state_d;
  logic [SW-1:0]    stab_q, stab_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             long_q, long_d;
  logic [CNT_W-1:0] count_q, count_d;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_presc (
    .clk   (clk),
    .reset (reset),
    .tick  (tick_s)
  );

  // Two-flop synchroniser for the asynchronous button pin.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], btn_in};
    end
  end

  assign btn_s = sync_q[1];

  // Debounce FSM; only advances on sample ticks.
  always_comb begin
    state_d   = state_q;
    stab_d    = stab_q;
    hold_d    = hold_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    if (tick_s) begin
      case (state_q)
        ST_RELEASED: begin
          if (btn_s) begin
            state_d = ST_PRESS_PEND;
            stab_d  = SW'(1);
          end else begin
            state_d = ST_RELEASED;
          end
        end
        ST_PRESS_PEND: begin
          if (!btn_s) begin
            state_d = ST_RELEASED;
            stab_d  = '0;
          end else if (stab_q == STAB_LAST) begin
            state_d = ST_PRESSED;
            stab_d  = '0;
            level_d = 1'b1;
            press_d = 1'b1;
            hold_d  = '0;
          end else begin
            stab_d = stab_q + SW'(1);
          end
        end
        ST_PRESSED: begin
          if (!btn_s) begin
            state_d = ST_RELEASE_PEND;
            stab_d  = SW'(1);
          end else if (hold_q != HOLD_MAX) begin
            hold_d = hold_q + HW'(1);
            long_d = (hold_q == HOLD_PRE);
          end else begin
            hold_d = hold_q;
          end
        end
        ST_RELEASE_PEND: begin
          // A bounce back to pressed keeps hold, so no second long pulse.
          if (btn_s) begin
            state_d = ST_PRESSED;
            stab_d  = '0;
          end else if (stab_q == STAB_LAST) begin
            state_d   = ST_RELEASED;
            stab_d    = '0;
            level_d   = 1'b0;
            release_d = 1'b1;
          end else begin
            stab_d = stab_q + SW'(1);
          end
        end
        default: begin
          state_d = ST_RELEASED;
          stab_d  = '0;
          hold_d  = '0;
          level_d = 1'b0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Press counter; clear wins over a coincident increment.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (press_d) begin
      count_d = count_q + CNT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // FSM, pulse and count registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_RELEASED;
      stab_q    <= '0;
      hold_q    <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      stab_q    <= stab_d;
      hold_q    <= hold_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      count_q   <= count_d;
    end
  end

  assign btn_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign long_pulse    = long_q;
  assign count         = count_q;

endmodule
